// File: rtl/piso_tx.sv
// ---------------------------------------------------------------------------
// piso_tx : parallel-in, serial-out transmitter
//
// Accepts a WIDTH-bit word through a valid/ready load handshake and sends it
// out LSB first on 'so'. The line moves one bit per slow tick. The tick comes
// from a free-running divider of TICK_DIV clk cycles. The matching SIPO
// receiver shifts in at its MSB at the same tick rate and rebuilds the word.
//
// Optional feature macro: PISO_PARITY_EN
//   defined   -> an even-parity bit (XOR of all pi bits) follows pi[WIDTH-1],
//                so a frame is WIDTH+1 bits long
//   undefined -> plain WIDTH-bit frames, no parity logic
//
// Parameters
//   WIDTH      data word width (>= 2)
//   TICK_DIV   clk cycles per shift tick (>= 2)
//
// Ports
//   clk         in   system clock, rising edge
//   rst         in   synchronous active-low reset
//   pi          in   parallel word, sampled only on an accepted load
//   load_valid  in   load request
//   load_ready  out  high while idle
//   en          in   shift enable; ticks seen while low are dropped
//   so          out  registered serial data
//   busy        out  high while a frame is on the line
//   done        out  one-cycle pulse when the last bit period ends
// ---------------------------------------------------------------------------
module piso_tx #(
  parameter int WIDTH    = 4,
  parameter int TICK_DIV = 100_000_000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] pi,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic             en,
  output logic             so,
  output logic             busy,
  output logic             done
);

  localparam int            CW      = $clog2(TICK_DIV);
  localparam logic [CW-1:0] DIV_MAX = CW'(TICK_DIV - 1);

`ifdef PISO_PARITY_EN
  localparam int NBITS = WIDTH + 1;
`else
  localparam int NBITS = WIDTH;
`endif

  localparam int            BW       = $clog2(NBITS);
  localparam logic [BW-1:0] LAST_BIT = BW'(NBITS - 1);

  typedef enum logic {
    S_IDLE,
    S_SHIFT
  } state_t;

  state_t           r_state;
  logic [CW-1:0]    r_divCnt;
  logic             r_tick;
  // Holds only the bits still waiting behind the one currently on 'so'.
  logic [NBITS-2:0] r_shift;
  logic [BW-1:0]    r_bitCnt;
  logic             r_so;
  logic             r_busy;
  logic             r_loadReady;
  logic             r_done;

  logic [NBITS-1:0] w_frame;
  logic             w_shiftStep;

`ifdef PISO_PARITY_EN
  assign w_frame = {^pi, pi};
`else
  assign w_frame = pi;
`endif

  assign w_shiftStep = r_tick & en;

  // Free-running tick divider. It never restarts on a load, so the first
  // bit period of a frame can be shorter than TICK_DIV cycles.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_divCnt <= '0;
      r_tick   <= 1'b0;
    end else begin
      r_tick <= (r_divCnt == DIV_MAX);
      if (r_divCnt == DIV_MAX) begin
        r_divCnt <= '0;
      end else begin
        r_divCnt <= r_divCnt + 1'b1;
      end
    end
  end

  // Frame state machine. A load puts bit 0 straight onto 'so'. A tick that
  // lands on the load edge is ignored by the new frame, because the IDLE
  // branch never looks at the tick.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_shift     <= '0;
      r_bitCnt    <= '0;
      r_so        <= 1'b0;
      r_busy      <= 1'b0;
      r_loadReady <= 1'b1;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (load_valid) begin
            r_state     <= S_SHIFT;
            r_shift     <= w_frame[NBITS-1:1];
            r_bitCnt    <= '0;
            r_so        <= w_frame[0];
            r_busy      <= 1'b1;
            r_loadReady <= 1'b0;
          end
        end
        S_SHIFT: begin
          if (w_shiftStep) begin
            if (r_bitCnt < LAST_BIT) begin
              r_so     <= r_shift[0];
              r_shift  <= r_shift >> 1;
              r_bitCnt <= r_bitCnt + 1'b1;
            end else begin
              r_state     <= S_IDLE;
              r_so        <= 1'b0;
              r_busy      <= 1'b0;
              r_loadReady <= 1'b1;
              r_done      <= 1'b1;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign so         = r_so;
  assign busy       = r_busy;
  assign load_ready = r_loadReady;
  assign done       = r_done;

endmodule

// File: tb/tb_piso_tx.sv
// ---------------------------------------------------------------------------
// tb_piso_tx : scoreboard bench for piso_tx (WIDTH=4, TICK_DIV=4)
//
// The reference model works at the frame level. It knows from the edge count
// after reset when the free-running divider ticks, and it books NBITS
// qualified ticks for each accepted frame. On every accepted load it pushes
// the expected frame word into a queue. The monitor rebuilds each frame from
// 'so' the way a receiver would, then pops and compares when 'done' arrives.
// Honours PISO_PARITY_EN in the same way as the design.
// ---------------------------------------------------------------------------
module tb_piso_tx;

  localparam int WIDTH    = 4;
  localparam int TICK_DIV = 4;
  localparam int CLK_HALF = 5;

`ifdef PISO_PARITY_EN
  localparam int NBITS = WIDTH + 1;
`else
  localparam int NBITS = WIDTH;
`endif

  logic             clk;
  logic             rst;
  logic [WIDTH-1:0] pi;
  logic             load_valid;
  logic             load_ready;
  logic             en;
  logic             so;
  logic             busy;
  logic             done;

  int nCompared = 0;
  int nMismatch = 0;

  // Reference model state, updated on each rising edge from inputs only
  logic [NBITS-1:0] expQ[$];
  bit               started   = 0;
  int               edgeCnt   = 0;
  bit               mBusy     = 0;
  bit               mDone     = 0;
  int               ticksLeft = 0;
  bit               evLoad    = 0;
  bit               evQual    = 0;
  bit               evReset   = 0;

  // Monitor state
  bit               rxActive = 0;
  int               rxCnt    = 0;
  logic [NBITS-1:0] rxWord   = '0;
  logic             prevSo   = 1'b0;

  piso_tx #(
    .WIDTH    (WIDTH),
    .TICK_DIV (TICK_DIV)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .pi         (pi),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .en         (en),
    .so         (so),
    .busy       (busy),
    .done       (done)
  );

  // Free-running clock
  initial begin
    clk = 1'b0;
    forever #CLK_HALF clk = ~clk;
  end

  // Hard stop if the run ever stalls
  initial begin
    #(2 * CLK_HALF * 60000);
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, required finish");
    $fatal(1, "[TB] watchdog");
  end

  function automatic logic [NBITS-1:0] frameOf(input logic [WIDTH-1:0] w);
`ifdef PISO_PARITY_EN
    return {^w, w};
`else
    return w;
`endif
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    nCompared++;
    if (actual !== expected) begin
      nMismatch++;
      $display("[TB] FAIL %s: got %0h, required %0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Reference model. The divider ticks once every TICK_DIV edges, starting
  // TICK_DIV edges after reset. The edge after a tick cycle is a shift edge
  // when en is high.
  always @(posedge clk) begin
    evLoad  = 0;
    evQual  = 0;
    evReset = 0;
    mDone   = 0;
    if (!rst) begin
      started   = 1;
      edgeCnt   = 0;
      mBusy     = 0;
      ticksLeft = 0;
      evReset   = 1;
      expQ.delete();
    end else begin
      edgeCnt++;
      evQual = (edgeCnt >= TICK_DIV + 1) && (edgeCnt % TICK_DIV == 1) && (en == 1'b1);
      if (!mBusy) begin
        if (load_valid) begin
          expQ.push_back(frameOf(pi));
          mBusy     = 1;
          ticksLeft = NBITS;
          evLoad    = 1;
        end
      end else if (evQual) begin
        ticksLeft--;
        if (ticksLeft == 0) begin
          mBusy = 0;
          mDone = 1;
        end
      end
    end
  end

  // Monitor: checks status every cycle, rebuilds frames from 'so' and checks
  // them against the scoreboard queue when 'done' appears.
  always @(negedge clk) begin
    if (started) begin
      checkOutput("busy", busy, mBusy);
      checkOutput("load_ready", load_ready, !mBusy);
      checkOutput("done", done, mDone);
      if (!mBusy) checkOutput("so_idle", so, 0);

      if (evReset) begin
        rxActive = 0;
      end else if (evLoad) begin
        rxWord    = '0;
        rxWord[0] = so;
        rxCnt     = 1;
        rxActive  = 1;
      end else if (rxActive && mBusy) begin
        if (evQual) begin
          if (rxCnt < NBITS) rxWord[rxCnt] = so;
          rxCnt++;
        end else begin
          checkOutput("so_hold", so, prevSo);
        end
      end

      if (mDone && rxActive) begin
        checkOutput("frame_bits", rxCnt, NBITS);
        if (expQ.size() == 0) begin
          checkOutput("scoreboard_empty", 1, 0);
        end else begin
          checkOutput("frame_data", rxWord, expQ.pop_front());
        end
        rxActive = 0;
      end
      prevSo = so;
    end
  end

  task automatic stepCycle();
    @(posedge clk);
    #2;
  endtask

  task automatic waitIdle();
    int n;
    n = 0;
    while (mBusy && n < 500) begin
      stepCycle();
      n++;
    end
    if (mBusy) begin
      nCompared++;
      nMismatch++;
      $display("[TB] FAIL frame_timeout: got busy after %0d cycles, required idle", n);
    end
    stepCycle();
  endtask

  // Issue one load pulse, optionally waiting for the frame to finish
  task automatic applyStimulus(input logic [WIDTH-1:0] word, input bit waitDone);
    pi         = word;
    load_valid = 1'b1;
    stepCycle();
    load_valid = 1'b0;
    pi         = WIDTH'($urandom);
    if (waitDone) waitIdle();
  endtask

  initial begin
    rst        = 1'b0;
    load_valid = 1'b0;
    en         = 1'b1;
    pi         = '0;
    repeat (3) stepCycle();
    checkOutput("reset_so", so, 0);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_ready", load_ready, 1);
    checkOutput("reset_done", done, 0);
    rst = 1'b1;
    stepCycle();

    $display("[TB] basic frame 1011");
    applyStimulus(4'b1011, 1);

    $display("[TB] parity-style word 0111");
    applyStimulus(4'b0111, 1);

    $display("[TB] busy rejection");
    applyStimulus(4'b1011, 0);
    repeat (3) stepCycle();
    applyStimulus(4'b0110, 0);
    waitIdle();

    $display("[TB] enable freeze");
    applyStimulus(4'b1011, 0);
    repeat (5) stepCycle();
    en = 1'b0;
    repeat (10) stepCycle();
    en = 1'b1;
    waitIdle();

    $display("[TB] mid-frame reset");
    applyStimulus(4'b1101, 0);
    repeat (7) stepCycle();
    rst = 1'b0;
    stepCycle();
    checkOutput("midrst_so", so, 0);
    checkOutput("midrst_busy", busy, 0);
    checkOutput("midrst_ready", load_ready, 1);
    checkOutput("midrst_done", done, 0);
    rst = 1'b1;
    repeat (8) stepCycle();

    $display("[TB] load coincident with tick");
    for (int k = 0; k < 3; k++) begin
      while (!(edgeCnt >= TICK_DIV && edgeCnt % TICK_DIV == 0)) stepCycle();
      applyStimulus(WIDTH'($urandom), 1);
    end

    $display("[TB] back-to-back frames");
    for (int k = 0; k < 4; k++) begin
      applyStimulus(WIDTH'($urandom), 0);
      while (!done) stepCycle();
    end
    waitIdle();

    $display("[TB] randomized traffic");
    for (int c = 0; c < 1500; c++) begin
      en         = ($urandom_range(0, 99) < 85);
      load_valid = ($urandom_range(0, 3) == 0);
      pi         = WIDTH'($urandom);
      rst        = ($urandom_range(0, 299) != 0);
      stepCycle();
    end
    rst        = 1'b1;
    en         = 1'b1;
    load_valid = 1'b0;
    waitIdle();
    repeat (2) stepCycle();
    checkOutput("scoreboard_drained", expQ.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
    $finish;
  end

endmodule
